// File: rtl/imem_dmem_arbiter_if.sv
// Requester and memory-side signal bundle for the unified IF/MEM memory arbiter.
// Pure wiring; the arbiter takes the slave view and the pipeline plus memory take the master view.
// Backpressure is through the gnt/stall pair per requester.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_stall;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_stall, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_stall, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between fetch and load/store; data port wins unless fetch is starved.
// Grant is combinational, read data returns exactly one cycle after grant, 1 access/cycle throughput.
// Losers see stall=req&~gnt the same cycle; ARB_PERF_CNT_EN adds saturating stall counters.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_dmem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]          if_stall_cnt,
    output logic [15:0]          dm_stall_cnt
`endif
);
    // One-hot so each rvalid is a flop bit directly.
    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_IF   = 2'b01,
        RESP_DM   = 2'b10
    } resp_t;

    resp_t             owner;
    logic [3:0]        starve_cnt;
    logic              starved;
    logic              if_win;
    logic              dm_win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign starved = (starve_cnt == 4'(STARVE_MAX));
    assign if_win  = ~rst & bus.if_req & (~bus.dm_req | starved);
    assign dm_win  = ~rst & bus.dm_req & ~if_win;

    assign bus.if_gnt   = if_win;
    assign bus.dm_gnt   = dm_win;
    assign bus.if_stall = bus.if_req & ~if_win;
    assign bus.dm_stall = bus.dm_req & ~dm_win;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        if (if_win) begin
            sel_addr = bus.if_addr;
        end else if (dm_win) begin
            sel_addr  = bus.dm_addr;
            sel_wdata = bus.dm_wdata;
        end
    end

    assign bus.mem_en    = if_win | dm_win;
    assign bus.mem_we    = dm_win & bus.dm_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= RESP_NONE;
            starve_cnt <= 4'd0;
        end else begin
            if (if_win)
                owner <= RESP_IF;
            else if (dm_win && !bus.dm_we)
                owner <= RESP_DM;
            else
                owner <= RESP_NONE;

            if (!bus.if_req || if_win)
                starve_cnt <= 4'd0;
            else if (!starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign bus.if_rvalid = owner[0];
    assign bus.dm_rvalid = owner[1];
    assign bus.if_rdata  = owner[0] ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = owner[1] ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_cnt <= 16'd0;
            dm_stall_cnt <= 16'd0;
        end else begin
            if (bus.if_stall && if_stall_cnt != 16'hFFFF)
                if_stall_cnt <= if_stall_cnt + 16'd1;
            if (bus.dm_stall && dm_stall_cnt != 16'hFFFF)
                dm_stall_cnt <= dm_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed plus randomized bench for imem_dmem_arbiter against a cycle-level reference model.
module tb_imem_dmem_arbiter;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] if_stall_cnt;
    logic [15:0] dm_stall_cnt;
`endif

    imem_dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_stall_cnt(if_stall_cnt),
        .dm_stall_cnt(dm_stall_cnt)
`endif
    );

    // Memory: registered read, write on mem_we, preloaded on the first edge.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1<<ADDR_W); i++)
                mem[i] <= 32'hA500_0000 + 32'(i);
            mem[1] <= 32'h0030_0093;
            mem_loaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rule from request pattern and consecutive-denial count.
    bit          model_on = 1'b0;
    int          denials  = 0;
    bit          exp_if_rv = 1'b0, exp_dm_rv = 1'b0;
    logic [31:0] exp_if_rd = '0, exp_dm_rd = '0;
    int          perf_if = 0, perf_dm = 0;

    always @(negedge clk) begin
        bit          g_if, g_dm;
        logic [31:0] e_addr, e_wdata;
        if (model_on) begin
            if (rst) begin
                g_if = 1'b0; g_dm = 1'b0;
            end else if (bus.if_req && bus.dm_req) begin
                g_if = (denials == STARVE_MAX);
                g_dm = !g_if;
            end else begin
                g_if = bus.if_req; g_dm = bus.dm_req;
            end
            e_addr  = g_if ? 32'(bus.if_addr) : (g_dm ? 32'(bus.dm_addr) : 32'd0);
            e_wdata = g_dm ? bus.dm_wdata : 32'd0;

            chk("m_if_gnt",    32'(bus.if_gnt),    32'(g_if));
            chk("m_dm_gnt",    32'(bus.dm_gnt),    32'(g_dm));
            chk("m_if_stall",  32'(bus.if_stall),  32'(bus.if_req & !g_if));
            chk("m_dm_stall",  32'(bus.dm_stall),  32'(bus.dm_req & !g_dm));
            chk("m_mem_en",    32'(bus.mem_en),    32'(g_if | g_dm));
            chk("m_mem_we",    32'(bus.mem_we),    32'(g_dm & bus.dm_we));
            chk("m_mem_addr",  32'(bus.mem_addr),  e_addr);
            chk("m_mem_wdata", bus.mem_wdata,      e_wdata);
            chk("m_if_rvalid", 32'(bus.if_rvalid), 32'(exp_if_rv));
            chk("m_dm_rvalid", 32'(bus.dm_rvalid), 32'(exp_dm_rv));
            chk("m_if_rdata",  bus.if_rdata,       exp_if_rd);
            chk("m_dm_rdata",  bus.dm_rdata,       exp_dm_rd);
`ifdef ARB_PERF_CNT_EN
            chk("m_if_stall_cnt", 32'(if_stall_cnt), 32'(perf_if));
            chk("m_dm_stall_cnt", 32'(dm_stall_cnt), 32'(perf_dm));
`endif
            if (rst) begin
                exp_if_rv = 1'b0; exp_if_rd = '0;
                exp_dm_rv = 1'b0; exp_dm_rd = '0;
                denials = 0; perf_if = 0; perf_dm = 0;
            end else begin
                exp_if_rv = g_if;
                exp_if_rd = g_if ? mem[bus.if_addr] : 32'd0;
                exp_dm_rv = g_dm && !bus.dm_we;
                exp_dm_rd = exp_dm_rv ? mem[bus.dm_addr] : 32'd0;
                if (bus.if_req && !g_if)
                    denials = (denials < STARVE_MAX) ? denials + 1 : STARVE_MAX;
                else
                    denials = 0;
                if (bus.if_req && !g_if && perf_if < 65535) perf_if++;
                if (bus.dm_req && !g_dm && perf_dm < 65535) perf_dm++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    endtask

    bit if_pend = 1'b0, dm_pend = 1'b0;

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        // Reset: requester asserted during reset reads stalled, nothing granted.
        tick();
        model_on = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 6'd7;
        mid();
        chk("rst_if_gnt",   32'(bus.if_gnt),   32'd0);
        chk("rst_if_stall", 32'(bus.if_stall), 32'd1);
        chk("rst_mem_en",   32'(bus.mem_en),   32'd0);
        tick();
        rst = 1'b0; idle();
        mid();
        chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("post_rst_if_rdata",  bus.if_rdata,       32'd0);

        // Fetch alone.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 6'd1;
        mid();
        chk("fetch_gnt",  32'(bus.if_gnt),   32'd1);
        chk("fetch_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        idle();
        mid();
        chk("fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("fetch_rdata",  bus.if_rdata,       32'h0030_0093);

        // Contention: DM, DM, DM, IF, DM.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 6'd5;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 6'd3;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk($sformatf("cont%0d_dm_gnt", c),   32'(bus.dm_gnt),   32'(c != 3));
            chk($sformatf("cont%0d_if_gnt", c),   32'(bus.if_gnt),   32'(c == 3));
            chk($sformatf("cont%0d_if_stall", c), 32'(bus.if_stall), 32'(c != 3));
            if (c > 0) begin
                chk($sformatf("cont%0d_if_rvalid", c), 32'(bus.if_rvalid), 32'(c == 4));
                chk($sformatf("cont%0d_dm_rvalid", c), 32'(bus.dm_rvalid), 32'(c != 4));
            end
            if (c == 4)
                chk("cont_if_rdata", bus.if_rdata, 32'hA500_0005);
            tick();
        end
        idle();
        mid();
        chk("cont_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
        chk("cont_dm_rdata",  bus.dm_rdata,       32'hA500_0003);

        // Store produces no response.
        tick();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 6'd12; bus.dm_wdata = 32'hDEAD_BEEF;
        mid();
        chk("st_mem_en",    32'(bus.mem_en), 32'd1);
        chk("st_mem_we",    32'(bus.mem_we), 32'd1);
        chk("st_mem_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
        tick();
        idle();
        mid();
        chk("st_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
        chk("st_if_rvalid", 32'(bus.if_rvalid), 32'd0);

        // Back-to-back IF then DM, then read back the store.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 6'd2;
        tick();
        bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 6'd4;
        mid();
        chk("b2b_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("b2b_if_rdata",  bus.if_rdata,       32'hA500_0002);
        chk("b2b_dm_gnt",    32'(bus.dm_gnt),    32'd1);
        tick();
        bus.dm_addr = 6'd12;
        mid();
        chk("b2b_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
        chk("b2b_dm_rdata",  bus.dm_rdata,       32'hA500_0004);
        chk("b2b_if_idle",   32'(bus.if_rvalid), 32'd0);
        tick();
        idle();
        mid();
        chk("st_readback", bus.dm_rdata, 32'hDEAD_BEEF);

        // Reset mid-contention clears the starvation count.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 6'd9;
        bus.dm_req = 1'b1; bus.dm_addr = 6'd10;
        tick();
        tick();
        rst = 1'b1;
        mid();
        chk("rstc_if_gnt",   32'(bus.if_gnt),   32'd0);
        chk("rstc_dm_gnt",   32'(bus.dm_gnt),   32'd0);
        chk("rstc_dm_stall", 32'(bus.dm_stall), 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            if (c == 0) begin
                chk("rstc_if_rvalid", 32'(bus.if_rvalid), 32'd0);
                chk("rstc_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
            end
            chk($sformatf("rstc%0d_if_gnt", c), 32'(bus.if_gnt), 32'(c == 3));
            tick();
        end
        idle();

`ifdef ARB_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0;
        repeat (8) tick();
        idle();
        mid();
        chk("perf_if_stall_cnt", 32'(if_stall_cnt), 32'd6);
        chk("perf_dm_stall_cnt", 32'(dm_stall_cnt), 32'd2);
`endif

        // Random traffic: pending requests are usually held, occasionally dropped.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(255) == 0);
            if (!(if_pend && $urandom_range(7) != 0)) begin
                bus.if_req  = ($urandom_range(2) != 0);
                bus.if_addr = 6'($urandom);
            end
            if (!(dm_pend && $urandom_range(7) != 0)) begin
                bus.dm_req   = ($urandom_range(3) != 0);
                bus.dm_we    = ($urandom_range(2) == 0);
                bus.dm_addr  = 6'($urandom);
                bus.dm_wdata = $urandom;
            end
            mid();
            if_pend = bus.if_req && !bus.if_gnt;
            dm_pend = bus.dm_req && !bus.dm_gnt;
        end
        tick();
        rst = 1'b0; idle();
        tick();
        mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
